if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Parametrised IF->ID decoupling stage: a DEPTH-entry FIFO of fetched instruction packets {pc, inst, predict, next_pc}.
//  - Replaces the single-entry IF/ID latch, so IF can run ahead while ID is held.
//  - Keeps the global stall-code (Pass/Hold/Bubb) semantics and the branch_error flush.
//  - Adds valid/ready handshakes on both sides.
// PARAMETERS
//  ADDR_W   32  width of pc / next_pc
//  INST_W   32  width of inst
//  DEPTH     4  queue entries; power of two, >=2
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  stall          in   2       stall code for ID side: `Pass / `Hold / `Bubb
//  branch_error   in   1       flush: discard all queued and incoming packets
//  in_valid       in   1       IF presents a packet
//  in_ready       out  1       queue accepts packet this cycle
//  pc_i           in   ADDR_W  fetched pc
//  inst_i         in   INST_W  fetched instruction
//  predict_i      in   1       branch-predictor taken bit
//  next_pc_i      in   ADDR_W  predicted next pc
//  out_valid      out  1       head packet presented to ID
//  out_ready      in   1       ID consumes head packet
//  pc_o / inst_o / predict_o / next_pc_o  out  as inputs   head packet; all zero when out_valid=0
//  count_o        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: rst=1 at posedge -> count=0, pointers=0; out_valid=0, all payload outputs 0, in_ready=1 next cycle.
//  Enqueue: in_valid & in_ready & !branch_error. in_ready = (count<DEPTH); it does not depend on out_ready.
//  Dequeue: out_valid & out_ready & stall==`Pass & !branch_error.
//  Latency: enqueue into an empty queue -> out_valid=1 on the following cycle. Write-then-read only, no bypass.
//  Stall codes:
//   - `Pass: normal dequeue.
//   - `Hold: no dequeue; outputs frozen; enqueue still allowed.
//   - `Bubb: no dequeue; out_valid and payload forced 0 for that cycle only; queue contents kept.
//   - Any other stall code behaves as `Hold.
//  Flush: branch_error=1 has priority over everything except rst.
//   - Next cycle: count=0, pointers=0, out_valid=0.
//   - A same-cycle in_valid packet is dropped. A same-cycle out_ready does not count as a consume.
//  Simultaneous enq+deq: count unchanged; both pointers advance. When full, dequeue does not free a same-cycle slot.
//  Wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
//  Payload storage is not reset; outputs are masked to 0 whenever out_valid=0.
// CONFIGURATION
//  IFQ_BYPASS_EN:
//   - Defined: when the queue is empty, stall==`Pass and out_ready=1, an incoming packet goes straight to the outputs
//     in the same cycle and is not written.
//   - Defined: out_valid = in_valid in that case. Zero-cycle latency; flush still kills it.
//   - Undefined: strict one-cycle latency as above.
// STRUCTURE
//  Shared package/header riscv_defs: `StallBus, `Pass, `Hold, `Bubb, `InstAddrBus, `InstBus.
//  Sub-module: if_id_fifo_mem (DEPTH x (2*ADDR_W+INST_W+1) register array: write port, async read port).
//  Control (pointers, count, stall/flush decode) lives in if_id_queue.
// TESTING
//  1. Reset with in_valid=1 held -> out_valid=0, pc_o=0, count_o=0; first packet appears 1 cycle after rst drops.
//  2. Enqueue pc=0x100..0x10C (4 pkts), out_ready=0 -> count_o=4, in_ready=0; a 5th pkt at 0x110 is not accepted.
//  3. Full queue, stall=`Pass, out_ready=1 for 6 cycles, IF feeding 0x110.. -> output order 0x100,0x104,..., none lost, pointers wrap.
//  4. stall=`Bubb for 1 cycle with head 0x104 -> out_valid=0 that cycle; next cycle out_valid=1, pc_o=0x104.
//  5. count_o=3 plus branch_error with in_valid=1 pc=0x200 -> next cycle count_o=0, out_valid=0; 0x200 never emitted.
//  6. IFQ_BYPASS_EN, empty queue, in_valid pc=0x40 with out_ready=1 -> same-cycle pc_o=0x40, count_o stays 0.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF->ID decoupling queue.
//  - STALL_W / stall_e : stall-code bus width and encodings (Pass/Hold/Bubb); 2'b11 acts as Hold
//  - *_DEF             : default widths and depth
//  - pkt_width()       : stored packet width {pc, inst, predict, next_pc}
package if_id_queue_pkg;

    localparam int unsigned STALL_W    = 2;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;

    typedef enum logic [STALL_W-1:0] {
        STALL_PASS = 2'b00,
        STALL_HOLD = 2'b01,
        STALL_BUBB = 2'b10
    } stall_e;

    // Width of one stored packet: two addresses, one instruction, predict bit
    function automatic int unsigned pkt_width(input int unsigned addr_w, input int unsigned inst_w);
        return 2 * addr_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake/bus bundle between IF, the queue and ID.
//  master : IF producer + ID consumer (drives in_valid/payload_i/out_ready)
//  slave  : the queue (drives in_ready, out_valid, payload_o, count_o)
interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] pc_i;
    logic [INST_W-1:0] inst_i;
    logic              predict_i;
    logic [ADDR_W-1:0] next_pc_i;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              predict_o;
    logic [ADDR_W-1:0] next_pc_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output in_valid, pc_i, inst_i, predict_i, next_pc_i, out_ready,
        input  in_ready, out_valid, pc_o, inst_o, predict_o, next_pc_o, count_o
    );

    modport slave (
        input  in_valid, pc_i, inst_i, predict_i, next_pc_i, out_ready,
        output in_ready, out_valid, pc_o, inst_o, predict_o, next_pc_o, count_o
    );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Packet storage for the IF->ID queue: DEPTH x WIDTH register array,
// one synchronous write port, one asynchronous read port. Not reset.
//  clk, we, waddr, wdata : write port
//  raddr, rdata          : combinational read port
module if_id_fifo_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 97,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry FIFO of {pc, inst, predict, next_pc}
// with valid/ready on both sides, stall-code decode and branch_error flush.
//  clk, rst            : clock, synchronous active-high reset
//  stall               : ID-side stall code (Pass / Hold / Bubb, other = Hold)
//  branch_error        : flush queue and drop same-cycle incoming packet
//  bus (slave modport) : in_valid/in_ready/payload_i, out_valid/out_ready/payload_o, count_o
// Optional build macro IFQ_BYPASS_EN: an empty queue under Pass with
// out_ready=1 forwards the incoming packet combinationally without storing it.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_error,
    if_id_queue_if.slave       bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PKT_W = pkt_width(ADDR_W, INST_W);

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    logic             is_empty, is_full, pass, bubb;
    logic             bypass_take, enq, deq, out_valid;
    logic [PKT_W-1:0] in_pkt, head_pkt, out_pkt;

    assign in_pkt = {bus.pc_i, bus.inst_i, bus.predict_i, bus.next_pc_i};

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata (in_pkt),
        .raddr (rd_ptr),
        .rdata (head_pkt)
    );

    // Handshake decode and next-state computation
    always_comb begin
        is_empty    = (count == '0);
        is_full     = (count == CNT_W'(DEPTH));
        pass        = (stall == STALL_PASS);
        bubb        = (stall == STALL_BUBB);
        bypass_take = 1'b0;
        out_valid   = !is_empty && !bubb;
        out_pkt     = head_pkt;

`ifdef IFQ_BYPASS_EN
        // Empty and ready to consume: present the IF packet in the same cycle
        if (is_empty && pass && bus.out_ready) begin
            out_valid   = bus.in_valid && !branch_error;
            out_pkt     = in_pkt;
            bypass_take = bus.in_valid && !branch_error;
        end
`endif

        // Dequeue only from stored entries; a bypassed packet is never stored
        deq = !is_empty && !bubb && bus.out_ready && pass && !branch_error;
        enq = bus.in_valid && !is_full && !branch_error && !bypass_take;

        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (branch_error) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (enq) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (deq) rd_ptr_nxt = rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end

        if (!out_valid) begin
            out_pkt = '0;
        end
    end

    // Pointer / occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    assign bus.in_ready  = !is_full;
    assign bus.out_valid = out_valid;
    assign bus.count_o   = count;
    assign {bus.pc_o, bus.inst_o, bus.predict_o, bus.next_pc_o} = out_pkt;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: reset sequence, then a table of
// per-cycle vectors; payload order is tracked by a scoreboard queue.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] stall;
    logic       branch_error;

    always #5 clk = ~clk;

    if_id_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_error (branch_error),
        .bus          (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
        logic [31:0] npc;
    } pkt_t;

    typedef struct packed {
        logic [1:0]  st;
        logic        be;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic [2:0]  exp_cnt;
        logic        exp_ov;
        logic        exp_ir;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    pkt_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic pkt_t mk(input logic [31:0] pc);
        pkt_t p;
        p.pc   = pc;
        p.inst = pc ^ 32'hDEAD_BEEF;
        p.pred = pc[3];
        p.npc  = pc + 32'd8;
        return p;
    endfunction

    function automatic vec_t v(input logic [1:0] st, input logic be, input logic iv,
                               input logic [31:0] pc, input logic ordy,
                               input logic [2:0] cnt, input logic ov, input logic ir);
        vec_t r;
        r.st = st; r.be = be; r.iv = iv; r.pc = pc; r.ordy = ordy;
        r.exp_cnt = cnt; r.exp_ov = ov; r.exp_ir = ir;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, check pre-edge outputs, update the scoreboard, advance one cycle
    task automatic apply(input vec_t t, input int idx);
        pkt_t inp, exp_p;
        bit   take, deq, enq;
        inp              = mk(t.pc);
        stall            = t.st;
        branch_error     = t.be;
        bus.in_valid     = t.iv;
        bus.pc_i         = inp.pc;
        bus.inst_i       = inp.inst;
        bus.predict_i    = inp.pred;
        bus.next_pc_i    = inp.npc;
        bus.out_ready    = t.ordy;
        #1;
        take = BYP && (sb.size() == 0) && (t.st == STALL_PASS) && t.ordy && t.iv && !t.be;
        check($sformatf("v%0d count_o", idx),   32'(bus.count_o),   32'(t.exp_cnt));
        check($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'(t.exp_ov));
        check($sformatf("v%0d in_ready", idx),  32'(bus.in_ready),  32'(t.exp_ir));
        exp_p = '0;
        if (t.exp_ov) exp_p = take ? inp : ((sb.size() > 0) ? sb[0] : pkt_t'('0));
        check($sformatf("v%0d pc_o", idx),      bus.pc_o,              exp_p.pc);
        check($sformatf("v%0d inst_o", idx),    bus.inst_o,            exp_p.inst);
        check($sformatf("v%0d predict_o", idx), 32'(bus.predict_o),    32'(exp_p.pred));
        check($sformatf("v%0d next_pc_o", idx), bus.next_pc_o,         exp_p.npc);
        deq = t.exp_ov && t.ordy && (t.st == STALL_PASS) && !t.be && !take;
        enq = t.iv && t.exp_ir && !t.be && !take;
        if (t.be) begin
            sb.delete();
        end else begin
            if (deq && sb.size() > 0) void'(sb.pop_front());
            if (enq) sb.push_back(inp);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset and first-packet latency
        vecs[0]  = v(STALL_PASS, 0, 1, 32'h080, 0, 0, 0, 1);
        vecs[1]  = v(STALL_PASS, 0, 0, 32'h000, 1, 1, 1, 1);
        // Fill to full; fifth packet refused
        vecs[2]  = v(STALL_PASS, 0, 1, 32'h100, 0, 0, 0, 1);
        vecs[3]  = v(STALL_PASS, 0, 1, 32'h104, 0, 1, 1, 1);
        vecs[4]  = v(STALL_PASS, 0, 1, 32'h108, 0, 2, 1, 1);
        vecs[5]  = v(STALL_PASS, 0, 1, 32'h10C, 0, 3, 1, 1);
        vecs[6]  = v(STALL_PASS, 0, 1, 32'h110, 0, 4, 1, 0);
        // Six cycles of draining while IF keeps feeding; pointers wrap
        vecs[7]  = v(STALL_PASS, 0, 1, 32'h110, 1, 4, 1, 0);
        vecs[8]  = v(STALL_PASS, 0, 1, 32'h110, 1, 3, 1, 1);
        vecs[9]  = v(STALL_PASS, 0, 1, 32'h114, 1, 3, 1, 1);
        vecs[10] = v(STALL_PASS, 0, 1, 32'h118, 1, 3, 1, 1);
        vecs[11] = v(STALL_PASS, 0, 1, 32'h11C, 1, 3, 1, 1);
        vecs[12] = v(STALL_PASS, 0, 1, 32'h120, 1, 3, 1, 1);
        // Bubble hides head for one cycle; Hold and code 2'b11 keep contents
        vecs[13] = v(STALL_BUBB, 0, 0, 32'h000, 1, 3, 0, 1);
        vecs[14] = v(STALL_PASS, 0, 0, 32'h000, 0, 3, 1, 1);
        vecs[15] = v(STALL_HOLD, 0, 1, 32'h124, 1, 3, 1, 1);
        vecs[16] = v(2'b11,      0, 0, 32'h000, 1, 4, 1, 0);
        vecs[17] = v(STALL_PASS, 0, 0, 32'h000, 1, 4, 1, 0);
        // Flush with a same-cycle incoming packet
        vecs[18] = v(STALL_PASS, 1, 1, 32'h200, 1, 3, 1, 1);
        vecs[19] = v(STALL_PASS, 0, 0, 32'h000, 1, 0, 0, 1);
        vecs[20] = v(STALL_PASS, 0, 1, 32'h300, 0, 0, 0, 1);
        vecs[21] = v(STALL_PASS, 0, 0, 32'h000, 1, 1, 1, 1);
        vecs[22] = v(STALL_PASS, 0, 0, 32'h000, 1, 0, 0, 1);
        // Empty queue, packet offered with out_ready=1 (bypass or one-cycle latency)
        vecs[23] = v(STALL_PASS, 0, 1, 32'h040, 1, 0, BYP, 1);
        vecs[24] = v(STALL_PASS, 0, 0, 32'h000, 1, 3'(!BYP), !BYP, 1);
        vecs[25] = v(STALL_PASS, 0, 0, 32'h000, 0, 0, 0, 1);

        rst           = 1'b1;
        stall         = STALL_PASS;
        branch_error  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.pc_i      = 32'h080;
        bus.inst_i    = 32'h0;
        bus.predict_i = 1'b0;
        bus.next_pc_i = 32'h0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst pc_o",      bus.pc_o,           32'd0);
        check("rst count_o",   32'(bus.count_o),   32'd0);
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        check("end count_o vs scoreboard", 32'(bus.count_o), 32'(sb.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
